// File: rtl/reg_file_sb.sv
// Dual-write, dual-read GPR file with a per-register pending-write scoreboard.
// Define REG_FILE_BYPASS_EN to forward same-cycle write data to the read ports.
module reg_file_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  wen0,
    input  logic [ADDR_WIDTH-1:0] waddr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic                  wen1,
    input  logic [ADDR_WIDTH-1:0] waddr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    input  logic                  sb_set,
    input  logic [ADDR_WIDTH-1:0] sb_addr,
    input  logic [ADDR_WIDTH-1:0] raddr1,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  rbusy1,
    input  logic [ADDR_WIDTH-1:0] raddr2,
    output logic [DATA_WIDTH-1:0] rdata2,
    output logic                  rbusy2,
    output logic [ADDR_WIDTH:0]   busy_cnt
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]      busy_q, busy_d;
    logic [ADDR_WIDTH:0]   busy_cnt_q, busy_cnt_d;

    logic acc0, acc1, set_ok;

    // Writes are also gated by reset so nothing is forwarded while reset is held.
    assign acc0   = resetn && wen0 && (waddr0 != '0);
    assign acc1   = resetn && wen1 && (waddr1 != '0);
    assign set_ok = sb_set && (sb_addr != '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (acc0) mem_q[waddr0] <= wdata0;
            if (acc1) mem_q[waddr1] <= wdata1;
        end
    end

    // Clears first, then the set, so a newly issued producer keeps the bit.
    always_comb begin
        busy_d = busy_q;
        if (acc0)   busy_d[waddr0]  = 1'b0;
        if (acc1)   busy_d[waddr1]  = 1'b0;
        if (set_ok) busy_d[sb_addr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_comb begin
        busy_cnt_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_cnt_d = busy_cnt_d + {{ADDR_WIDTH{1'b0}}, busy_d[i]};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy_cnt = busy_cnt_q;

    always_comb begin
        rdata1 = (raddr1 == '0) ? '0 : mem_q[raddr1];
        rbusy1 = busy_q[raddr1];
        rdata2 = (raddr2 == '0) ? '0 : mem_q[raddr2];
        rbusy2 = busy_q[raddr2];
`ifdef REG_FILE_BYPASS_EN
        if (acc1 && (waddr1 == raddr1)) begin
            rdata1 = wdata1;
            rbusy1 = 1'b0;
        end else if (acc0 && (waddr0 == raddr1)) begin
            rdata1 = wdata0;
            rbusy1 = 1'b0;
        end
        if (acc1 && (waddr1 == raddr2)) begin
            rdata2 = wdata1;
            rbusy2 = 1'b0;
        end else if (acc0 && (waddr0 == raddr2)) begin
            rdata2 = wdata0;
            rbusy2 = 1'b0;
        end
`endif
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed self-checking bench for reg_file_sb; expectations follow the
// REG_FILE_BYPASS_EN setting of the build.
module tb_reg_file_sb;

    logic        clk = 1'b0;
    logic        resetn;
    logic        wen0, wen1, sb_set;
    logic [4:0]  waddr0, waddr1, sb_addr, raddr1, raddr2;
    logic [31:0] wdata0, wdata1;
    logic [31:0] rdata1, rdata2;
    logic        rbusy1, rbusy2;
    logic [5:0]  busy_cnt;

    int errors = 0;
    int checks = 0;

`ifdef REG_FILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    always #5 clk = ~clk;

    reg_file_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk(clk), .resetn(resetn),
        .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
        .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
        .sb_set(sb_set), .sb_addr(sb_addr),
        .raddr1(raddr1), .rdata1(rdata1), .rbusy1(rbusy1),
        .raddr2(raddr2), .rdata2(rdata2), .rbusy2(rbusy2),
        .busy_cnt(busy_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn = 1'b0;
        wen0 = 0; wen1 = 0; sb_set = 0;
        waddr0 = 0; waddr1 = 0; sb_addr = 0; raddr1 = 0; raddr2 = 0;
        wdata0 = 0; wdata1 = 0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i);
            raddr2 = 5'(31 - i);
            #1;
            check("rst_rdata1", rdata1, 0);
            check("rst_rbusy1", rbusy1, 0);
            check("rst_rdata2", rdata2, 0);
            check("rst_rbusy2", rbusy2, 0);
        end
        check("rst_busy_cnt", busy_cnt, 0);
        @(negedge clk);
        resetn = 1'b1;
        tick();

        // Write to 5 with same-cycle read
        wen0 = 1; waddr0 = 5; wdata0 = 32'hDEADBEEF; raddr1 = 5;
        #1;
        check("wr5_same", rdata1, BYP ? 32'hDEADBEEF : 32'h0);
        tick();
        wen0 = 0;
        #1;
        check("wr5_next", rdata1, 32'hDEADBEEF);

        // Dual write to 7: port 1 wins
        wen0 = 1; wen1 = 1; waddr0 = 7; waddr1 = 7; wdata0 = 1; wdata1 = 2; raddr2 = 7;
        #1;
        check("wr7_same", rdata2, BYP ? 32'h2 : 32'h0);
        tick();
        wen0 = 0; wen1 = 0;
        #1;
        check("wr7_prio", rdata2, 2);

        // Write to address 0 is ignored
        wen0 = 1; waddr0 = 0; wdata0 = 32'hFFFFFFFF; raddr1 = 0;
        #1;
        check("wr0_same", rdata1, 0);
        tick();
        wen0 = 0;
        #1;
        check("wr0_next", rdata1, 0);
        check("wr0_rbusy", rbusy1, 0);

        // Scoreboard set 3 then 9
        sb_set = 1; sb_addr = 3;
        tick();
        check("sb3_cnt", busy_cnt, 1);
        sb_addr = 9;
        tick();
        sb_set = 0; raddr1 = 3; raddr2 = 9;
        #1;
        check("sb_cnt2", busy_cnt, 2);
        check("sb_busy3", rbusy1, 1);
        check("sb_busy9", rbusy2, 1);

        // Write to 3 clears its busy bit; bypass hides it in the same cycle
        wen1 = 1; waddr1 = 3; wdata1 = 32'h33;
        #1;
        check("clr3_same_busy", rbusy1, BYP ? 1'b0 : 1'b1);
        check("clr3_same_busy9", rbusy2, 1);
        tick();
        wen1 = 0;
        #1;
        check("clr3_cnt", busy_cnt, 1);
        check("clr3_busy", rbusy1, 0);
        check("clr3_data", rdata1, 32'h33);

        // Set on address 0 has no effect
        sb_set = 1; sb_addr = 0;
        tick();
        sb_set = 0;
        #1;
        check("sb0_cnt", busy_cnt, 1);

        // Re-set of busy 9 and clear of non-busy 12 leave the count alone
        sb_set = 1; sb_addr = 9; wen0 = 1; waddr0 = 12; wdata0 = 32'hC;
        tick();
        sb_set = 0; wen0 = 0;
        #1;
        check("resetbusy_cnt", busy_cnt, 1);
        check("resetbusy_9", rbusy2, 1);

        // Set and write of 4 in the same cycle: set wins
        sb_set = 1; sb_addr = 4; wen0 = 1; waddr0 = 4; wdata0 = 32'hAA55;
        tick();
        sb_set = 0; wen0 = 0; raddr1 = 4;
        #1;
        check("setclr4_busy", rbusy1, 1);
        check("setclr4_data", rdata1, 32'hAA55);
        check("setclr4_cnt", busy_cnt, 2);

        // Write + set 10, then async reset mid-cycle
        wen0 = 1; waddr0 = 10; wdata0 = 32'h12345678; sb_set = 1; sb_addr = 10;
        tick();
        wen0 = 0; sb_set = 0; raddr1 = 10; raddr2 = 7;
        #1;
        check("r10_data", rdata1, 32'h12345678);
        check("r10_busy", rbusy1, 1);
        check("r10_cnt", busy_cnt, 3);
        #2;
        resetn = 1'b0;
        #1;
        check("arst_rdata1", rdata1, 0);
        check("arst_rbusy1", rbusy1, 0);
        check("arst_rdata2", rdata2, 0);
        check("arst_cnt", busy_cnt, 0);

        // A write presented while reset is held is discarded
        wen0 = 1; waddr0 = 10; wdata0 = 32'hBAD;
        @(posedge clk);
        #1;
        check("arst_wr_disc", rdata1, 0);
        wen0 = 0;
        @(negedge clk);
        resetn = 1'b1;
        tick();
        check("post_rdata10", rdata1, 0);
        check("post_rdata7", rdata2, 0);
        check("post_cnt", busy_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
